// File: rtl/fast_corner_score_if.sv
// Patch beat in / scored corner result out, shared by the sliding-window stage,
// the corner scorer and the non-maximum-suppression stage.
interface fast_corner_score_if #(
    parameter int COL_NUM     = 640,
    parameter int ROW_NUM     = 480,
    parameter int PIXEL_WIDTH = 8,
    parameter int XW          = $clog2(COL_NUM),
    parameter int YW          = $clog2(ROW_NUM),
    parameter int SCORE_W     = PIXEL_WIDTH + 4
);
    logic [56*PIXEL_WIDTH-1:0] patch_i;
    logic                      patch_vld_i;
    logic [XW-1:0]             x_i;
    logic [YW-1:0]             y_i;
    logic                      eol_i;
    logic [PIXEL_WIDTH-1:0]    thresh_i;

    logic                      corner_vld_o;
    logic                      corner0_o;
    logic                      corner1_o;
    logic [SCORE_W-1:0]        score0_o;
    logic [SCORE_W-1:0]        score1_o;
    logic [XW-1:0]             x_o;
    logic [YW-1:0]             y_o;
    logic                      eol_o;

    modport slave (
        input  patch_i, patch_vld_i, x_i, y_i, eol_i, thresh_i,
        output corner_vld_o, corner0_o, corner1_o, score0_o, score1_o, x_o, y_o, eol_o
    );

    modport master (
        output patch_i, patch_vld_i, x_i, y_i, eol_i, thresh_i,
        input  corner_vld_o, corner0_o, corner1_o, score0_o, score1_o, x_o, y_o, eol_o
    );
endinterface

// File: rtl/fast_corner_score.sv
// FAST-16 segment test and SAD-style score for the two 7x7 windows of an 8x7 patch,
// three registered stages, one beat per cycle, no backpressure.
module fast_corner_score #(
    parameter int COL_NUM     = 640,
    parameter int ROW_NUM     = 480,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fast_corner_score_if.slave  bus
);
    localparam int PW      = PIXEL_WIDTH;
    localparam int XW      = $clog2(COL_NUM);
    localparam int YW      = $clog2(ROW_NUM);
    localparam int SCORE_W = PIXEL_WIDTH + 4;

    localparam int DR [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};
    localparam int DC [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};

    localparam logic [XW-1:0] X_MIN  = XW'(3);
    localparam logic [XW-1:0] X_MAX  = XW'(COL_NUM - 4);
    localparam logic [YW-1:0] Y0_MIN = YW'(3);
    localparam logic [YW-1:0] Y0_MAX = YW'(ROW_NUM - 4);
    localparam logic [YW:0]   Y1_MIN = (YW+1)'(3);
    localparam logic [YW:0]   Y1_MAX = (YW+1)'(ROW_NUM - 4);

    // True when the 16-bit ring holds a run of at least 9 set bits, wrap included.
    function automatic logic has_run9(input logic [15:0] m);
        logic [31:0] dbl;
        has_run9 = 1'b0;
        dbl = {m, m};
        for (int s = 0; s < 16; s++) begin
            if (&dbl[s +: 9]) has_run9 = 1'b1;
        end
    endfunction

    logic [1:0][15:0]         w_bright;
    logic [1:0][15:0]         w_dark;
    logic [1:0][15:0][PW-1:0] w_d;

    for (genvar w = 0; w < 2; w++) begin : g_win
        localparam int CR = 3 + w;
        logic [PW-1:0] w_c;
        assign w_c = bus.patch_i[(CR*7+3)*PW +: PW];

        for (genvar k = 0; k < 16; k++) begin : g_pix
            localparam int PIX = (CR + DR[k]) * 7 + 3 + DC[k];
            logic [PW-1:0] w_p;
            logic [PW-1:0] w_abs;
            assign w_p            = bus.patch_i[PIX*PW +: PW];
            assign w_bright[w][k] = {1'b0, w_p} > ({1'b0, w_c} + {1'b0, bus.thresh_i});
            assign w_dark[w][k]   = ({1'b0, w_p} + {1'b0, bus.thresh_i}) < {1'b0, w_c};
            assign w_abs          = (w_p > w_c) ? (w_p - w_c) : (w_c - w_p);
            assign w_d[w][k]      = (w_abs > bus.thresh_i) ? (w_abs - bus.thresh_i) : '0;
        end
    end

    logic [1:0][15:0]         r_s1_bright;
    logic [1:0][15:0]         r_s1_dark;
    logic [1:0][15:0][PW-1:0] r_s1_d;
    logic [XW-1:0]            r_s1_x;
    logic [YW-1:0]            r_s1_y;
    logic                     r_s1_eol;
    logic                     r_s1_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_bright <= '0;
            r_s1_dark   <= '0;
            r_s1_d      <= '0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_eol    <= 1'b0;
            r_s1_vld    <= 1'b0;
        end else begin
            r_s1_bright <= w_bright;
            r_s1_dark   <= w_dark;
            r_s1_d      <= w_d;
            r_s1_x      <= bus.x_i;
            r_s1_y      <= bus.y_i;
            r_s1_eol    <= bus.eol_i;
            r_s1_vld    <= bus.patch_vld_i;
        end
    end

    logic [1:0]              w_seg;
    logic [1:0][SCORE_W-1:0] w_sum;

    for (genvar w = 0; w < 2; w++) begin : g_tree
        logic [7:0][SCORE_W-1:0] w_l1;
        logic [3:0][SCORE_W-1:0] w_l2;
        logic [1:0][SCORE_W-1:0] w_l3;

        for (genvar i = 0; i < 8; i++) begin : g_l1
            assign w_l1[i] = SCORE_W'(r_s1_d[w][2*i]) + SCORE_W'(r_s1_d[w][2*i+1]);
        end
        for (genvar i = 0; i < 4; i++) begin : g_l2
            assign w_l2[i] = w_l1[2*i] + w_l1[2*i+1];
        end
        for (genvar i = 0; i < 2; i++) begin : g_l3
            assign w_l3[i] = w_l2[2*i] + w_l2[2*i+1];
        end
        assign w_sum[w] = w_l3[0] + w_l3[1];
        assign w_seg[w] = has_run9(r_s1_bright[w]) | has_run9(r_s1_dark[w]);
    end

    logic [1:0]              r_s2_seg;
    logic [1:0][SCORE_W-1:0] r_s2_sum;
    logic [XW-1:0]           r_s2_x;
    logic [YW-1:0]           r_s2_y;
    logic                    r_s2_eol;
    logic                    r_s2_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_seg <= '0;
            r_s2_sum <= '0;
            r_s2_x   <= '0;
            r_s2_y   <= '0;
            r_s2_eol <= 1'b0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s2_seg <= w_seg;
            r_s2_sum <= w_sum;
            r_s2_x   <= r_s1_x;
            r_s2_y   <= r_s1_y;
            r_s2_eol <= r_s1_eol;
            r_s2_vld <= r_s1_vld;
        end
    end

    // The lower centre sits one row below y; the extra bit keeps y+1 from wrapping.
    logic [YW:0] w_y1;
    logic        w_x_in;
    logic        w_y0_in;
    logic        w_y1_in;
    logic [1:0]  w_corner;

    assign w_y1        = {1'b0, r_s2_y} + (YW+1)'(1);
    assign w_x_in      = (r_s2_x >= X_MIN) && (r_s2_x <= X_MAX);
    assign w_y0_in     = (r_s2_y >= Y0_MIN) && (r_s2_y <= Y0_MAX);
    assign w_y1_in     = (w_y1 >= Y1_MIN) && (w_y1 <= Y1_MAX);
    assign w_corner[0] = r_s2_seg[0] & w_x_in & w_y0_in;
    assign w_corner[1] = r_s2_seg[1] & w_x_in & w_y1_in;

    logic               r_corner_vld;
    logic               r_corner0;
    logic               r_corner1;
    logic [SCORE_W-1:0] r_score0;
    logic [SCORE_W-1:0] r_score1;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic               r_eol;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_corner_vld <= 1'b0;
            r_corner0    <= 1'b0;
            r_corner1    <= 1'b0;
            r_score0     <= '0;
            r_score1     <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_eol        <= 1'b0;
        end else begin
            r_corner_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_corner0 <= w_corner[0];
                r_corner1 <= w_corner[1];
                r_score0  <= w_corner[0] ? r_s2_sum[0] : '0;
                r_score1  <= w_corner[1] ? r_s2_sum[1] : '0;
                r_x       <= r_s2_x;
                r_y       <= r_s2_y;
                r_eol     <= r_s2_eol;
            end
        end
    end

    assign bus.corner_vld_o = r_corner_vld;
    assign bus.corner0_o    = r_corner0;
    assign bus.corner1_o    = r_corner1;
    assign bus.score0_o     = r_score0;
    assign bus.score1_o     = r_score1;
    assign bus.x_o          = r_x;
    assign bus.y_o          = r_y;
    assign bus.eol_o        = r_eol;
endmodule
